// File: rtl/bsk_led_mux.sv
// Time-multiplexed LED latch driver: scans enabled channels over one shared data bus,
// giving each slot a setup cycle, a latch-enable window and a hold cycle.
module bsk_led_mux #(
   parameter int WIDTH        = 16,
   parameter int CHANNELS     = 2,
   parameter int DWELL        = 10,
   parameter int BLINK_FRAMES = 50
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] iLed,
   input  logic [CHANNELS-1:0]       iEnable,
   input  logic [CHANNELS*WIDTH-1:0] iBlink,
   output logic [WIDTH-1:0]          oLed,
   output logic [CHANNELS-1:0]       oLe,
   output logic                      oFrame,
   output logic                      oDbgSlot
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int K_W  = $clog2(DWELL);
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [K_W-1:0]  K_LAST   = K_W'(DWELL - 1);
   localparam logic [K_W-1:0]  K_LE_LO  = K_W'(1);
   localparam logic [K_W-1:0]  K_LE_HI  = K_W'(DWELL - 2);
   localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SLOT = 1'b1
   } state_t;

   state_t            r_state;
   logic [CH_W-1:0]   r_ch;
   logic [K_W-1:0]    r_k;
   logic [FC_W-1:0]   r_fcnt;
   logic              r_ph;
   logic [WIDTH-1:0]  r_led;
   logic [CHANNELS-1:0] r_le;

   state_t            w_state_nxt;
   logic [CH_W-1:0]   w_ch_nxt;
   logic [K_W-1:0]    w_k_nxt;
   logic [FC_W-1:0]   w_fcnt_nxt;
   logic              w_ph_nxt;
   logic [WIDTH-1:0]  w_led_nxt;
   logic [CHANNELS-1:0] w_le_nxt;
   logic              w_frame;

   logic              w_any;
   logic              w_found_above;
   logic [CH_W-1:0]   w_lowest;
   logic [CH_W-1:0]   w_above;

   // Lowest enabled channel, and the lowest enabled channel above the current one.
   always_comb begin
      w_any         = |iEnable;
      w_lowest      = '0;
      w_above       = '0;
      w_found_above = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (iEnable[i]) begin
            w_lowest = CH_W'(i);
            if (i > int'(r_ch)) begin
               w_above       = CH_W'(i);
               w_found_above = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_k_nxt     = r_k;
      w_fcnt_nxt  = r_fcnt;
      w_ph_nxt    = r_ph;
      w_frame     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_SLOT;
               w_ch_nxt    = w_lowest;
               w_k_nxt     = '0;
            end
         end
         ST_SLOT: begin
            if (r_k != K_LAST) begin
               w_k_nxt = r_k + K_W'(1);
            end else begin
               w_k_nxt = '0;
               if (!w_any) begin
                  w_state_nxt = ST_IDLE;
                  w_fcnt_nxt  = '0;
               end else if (w_found_above) begin
                  w_ch_nxt = w_above;
               end else begin
                  // Wrapping back to the lowest enabled channel closes a frame.
                  w_ch_nxt = w_lowest;
                  w_frame  = 1'b1;
                  if (r_fcnt == FC_LAST) begin
                     w_fcnt_nxt = '0;
                     w_ph_nxt   = ~r_ph;
                  end else begin
                     w_fcnt_nxt = r_fcnt + FC_W'(1);
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_led_nxt = '0;
      w_le_nxt  = '0;
      if (w_state_nxt == ST_SLOT) begin
         w_led_nxt = iLed[int'(w_ch_nxt)*WIDTH +: WIDTH] &
                     ~(iBlink[int'(w_ch_nxt)*WIDTH +: WIDTH] & {WIDTH{w_ph_nxt}});
         if ((w_k_nxt >= K_LE_LO) && (w_k_nxt <= K_LE_HI)) begin
            w_le_nxt[w_ch_nxt] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ch    <= '0;
         r_k     <= '0;
         r_fcnt  <= '0;
         r_ph    <= 1'b0;
         r_led   <= '0;
         r_le    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_k     <= w_k_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_ph    <= w_ph_nxt;
         r_led   <= w_led_nxt;
         r_le    <= w_le_nxt;
      end
   end

   // The frame strobe follows the same enable sampling as the slot-end decision.
   assign oFrame   = w_frame;
   assign oLed     = r_led;
   assign oLe      = r_le;
   assign oDbgSlot = (r_state == ST_SLOT);

endmodule

// File: doc/bsk_led_mux.md
# bsk_led_mux

Parametrised time-multiplexed LED driver for the BSK front panel. It is the successor to the fixed two-group (transmitter/receiver) LED latch driver. It scans `CHANNELS` LED groups over one shared `WIDTH`-bit data bus and gives each group a one-hot latch-enable pulse with guaranteed setup and hold. It adds per-channel enable/skip, per-bit blinking and a frame strobe, and sits between the command-status logic and the external LED latches.

## Interface
Parameters:
- `WIDTH`, 16: LEDs per channel, i.e. shared bus width.
- `CHANNELS`, 2: number of latched LED groups. Range 1..16.
- `DWELL`, 10: clock cycles per channel slot. Minimum 3.
- `BLINK_FRAMES`, 50: completed frames per blink half-period. Minimum 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; one clock domain only.
- `iLed`  in  CHANNELS*WIDTH  LED data; channel c occupies bits [c*WIDTH +: WIDTH].
- `iEnable`  in  CHANNELS  per-channel scan enable; 0 means the channel is skipped.
- `iBlink`  in  CHANNELS*WIDTH  per-LED blink mask, with the same packing as `iLed`.
- `oLed`  out  WIDTH  shared LED data bus, registered.
- `oLe`  out  CHANNELS  one-hot latch enables, active-high, registered.
- `oFrame`  out  1  one-cycle strobe on the last cycle of a frame.

## Operation
- State: channel pointer `ch`, slot counter `k` (0..DWELL-1, width $clog2(DWELL)), frame counter (0..BLINK_FRAMES-1), blink phase `ph`, and an `idle` flag.
- Reset values: `oLed`=0, `oLe`=0, `oFrame`=0, `ch`=0, `k`=0, frame counter=0, `ph`=0, `idle`=1. Reset asserted mid-slot clears everything immediately, without waiting for a clock edge.
- IDLE (no slot active), evaluated every cycle:
  - If `iEnable`==0, remain in IDLE with `oLed`=0 and `oLe`=0.
  - Otherwise the next edge starts a slot (k=0) for the lowest enabled channel.
- SLOT for channel `ch`, at cycle `k`:
  - `oLed` = iLed[ch] & ~(iBlink[ch] & {WIDTH{ph}}). It is re-sampled every cycle, so input changes during a slot appear after one cycle.
  - `oLe[ch]` = 1 only for 1 <= k <= DWELL-2. Cycle 0 is setup and cycle DWELL-1 is hold; both have `oLe` low. All other `oLe` bits are always 0.
- Slot end (edge at k=DWELL-1):
  - The next channel is the next enabled index above `ch`, wrapping to the lowest enabled index.
  - `iEnable` is sampled only at this point. A channel disabled mid-slot finishes its slot.
  - If only one channel is enabled, it repeats back-to-back.
  - If no channel is enabled, go to IDLE.
- Frame end (wrap):
  - A wrap occurs when the next channel index is <= `ch`, including the single-channel case.
  - `oFrame`=1 during that slot's k=DWELL-1 cycle.
  - The frame counter increments. When it reaches BLINK_FRAMES-1 it clears and `ph` toggles.
- Entering IDLE clears the frame counter but keeps `ph`.

## Timing
- Outputs are registered, with one-cycle latency from `iLed`/`iBlink` to `oLed`.
- First slot: the first edge after `rst` falls, with `iEnable`≠0, produces k=0 with `oLe`=0 and `oLed` valid.
- With the default parameters a slot has 1 setup cycle, 8 cycles of `oLe` high and 1 hold cycle.
- Consecutive slots have no gap: the next slot's k=0 (`oLe` low) directly follows the previous hold cycle.
- Frame period = DWELL × (number of enabled channels) cycles.
- Blink period = 2 × BLINK_FRAMES × frame period.
- `oLed` never changes on a cycle where any `oLe` bit transitions 0→1 or 1→0 relative to the channel selection. Only the data value may change, and only while the same channel stays selected.

## Test plan
1. CHANNELS=2, DWELL=10, iLed[0]=16'hAAAA, iLed[1]=16'h5555, both enabled:
   - Cycles 0..9: `oLed`=AAAA, with `oLe`=2'b01 on cycles 1..8 only.
   - Cycles 10..19: `oLed`=5555, with `oLe`=2'b10 on cycles 11..18 only.
   - `oFrame`=1 on cycle 19.
   - Cycle 20: `oLed`=AAAA.
2. In the setup of scenario 1, change iLed[0] to 16'h1234 during cycle 3 → `oLed`=1234 from cycle 4, and `oLe[0]` stays high.
3. iEnable=2'b10 → only channel 1 is scanned.
   - `oLe[0]` is never 1.
   - `oFrame` pulses every 10 cycles.
   - Clearing iEnable during a slot lets that slot finish, then the block goes IDLE with `oLed`=0 and `oLe`=0.
4. BLINK_FRAMES=2, iBlink[0]=16'h000F, iLed[0]=16'hFFFF → channel 0 shows FFFF for 2 frames, then FFF0 for 2 frames, repeating.
5. Assert `rst` asynchronously mid-slot while `oLe`=2'b01 → `oLed`=0, `oLe`=0 and `oFrame`=0 before the next edge. After release, the scan restarts at channel 0 with k=0.
6. CHANNELS=4, iEnable=4'b1010 → channel order is 1,3,1,3, with `oFrame` on the last cycle of each channel-3 slot. The frame period is 20 cycles.
